// File: rtl/gpr_scoreboard.sv
// General register file with a per-register pending-write scoreboard.
// Reads are combinational with write-through bypass from the WB port.
module gpr_scoreboard #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        r0_num_i,
    input  logic [3:0]        r1_num_i,
    output logic [DATA_W-1:0] r0_data_o,
    output logic [DATA_W-1:0] r1_data_o,
    input  logic              w_reserve_i,
    input  logic [3:0]        rsv_num_i,
    output logic [NREG-1:0]   reserved_o,
    input  logic              wb_i,
    input  logic [3:0]        wbr_num_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              rsv_full_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs     [NREG];
    logic [CNT_W-1:0]  cnt      [NREG];
    logic [CNT_W-1:0]  cnt_next [NREG];
    logic              err;
    logic              err_set;
    logic [NREG-1:0]   reserved;

    always_comb begin
        err_set  = 1'b0;
        reserved = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next[i] = cnt[i];
            if (w_reserve_i && rsv_num_i == 4'(i) && !(wb_i && wbr_num_i == 4'(i))) begin
                if (cnt[i] != CNT_MAX) cnt_next[i] = cnt[i] + CNT_ONE;
                else                   err_set     = 1'b1;
            end else if (wb_i && wbr_num_i == 4'(i) && !(w_reserve_i && rsv_num_i == 4'(i))) begin
                if (cnt[i] != '0) cnt_next[i] = cnt[i] - CNT_ONE;
                else              err_set     = 1'b1;
            end
            // A retiring last write already reads as free; new reserves show up next cycle.
            if (wb_i && wbr_num_i == 4'(i) && cnt[i] != '0)
                reserved[i] = (cnt[i] - CNT_ONE) != '0;
            else
                reserved[i] = cnt[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wb_i) regs[wbr_num_i] <= wb_data_i;
            for (int i = 0; i < NREG; i++) cnt[i] <= cnt_next[i];
            if (err_set) err <= 1'b1;
        end
    end

    assign r0_data_o  = (wb_i && wbr_num_i == r0_num_i) ? wb_data_i : regs[r0_num_i];
    assign r1_data_o  = (wb_i && wbr_num_i == r1_num_i) ? wb_data_i : regs[r1_num_i];
    assign reserved_o = reserved;
    assign rsv_full_o = (cnt[rsv_num_i] == CNT_MAX) && !(wb_i && wbr_num_i == rsv_num_i);
    assign err_o      = err;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Bench for gpr_scoreboard: directed scenarios plus randomized traffic
// checked against an integer-count reference model of the register file.
module tb_gpr_scoreboard;

    logic        clk;
    logic        rst;
    logic [3:0]  r0_num_i, r1_num_i, rsv_num_i, wbr_num_i;
    logic [15:0] r0_data_o, r1_data_o, wb_data_i;
    logic        w_reserve_i, wb_i;
    logic [15:0] reserved_o;
    logic        rsv_full_o, err_o;

    gpr_scoreboard #(.DATA_W(16), .NREG(16), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_num_i   (r0_num_i),
        .r1_num_i   (r1_num_i),
        .r0_data_o  (r0_data_o),
        .r1_data_o  (r1_data_o),
        .w_reserve_i(w_reserve_i),
        .rsv_num_i  (rsv_num_i),
        .reserved_o (reserved_o),
        .wb_i       (wb_i),
        .wbr_num_i  (wbr_num_i),
        .wb_data_i  (wb_data_i),
        .rsv_full_o (rsv_full_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: plain pending-write counts and data values
    logic [15:0] regs_m [16];
    int          pend_m [16];
    bit          err_m;
    bit          chk_en;
    int          n_chk;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic apply(input logic r, input logic rsv, input logic [3:0] rn,
                         input logic wb, input logic [3:0] wn, input logic [15:0] wd,
                         input logic [3:0] a, input logic [3:0] b);
        rst = r; w_reserve_i = rsv; rsv_num_i = rn;
        wb_i = wb; wbr_num_i = wn; wb_data_i = wd;
        r0_num_i = a; r1_num_i = b;
        #1;
    endtask

    // Compare all outputs against the model, advance the model, wait for next drive point.
    task automatic tick();
        logic [15:0] exp_rsv;
        logic [15:0] e0, e1;
        bit          full;
        if (chk_en) begin
            e0 = (wb_i && wbr_num_i == r0_num_i) ? wb_data_i : regs_m[r0_num_i];
            e1 = (wb_i && wbr_num_i == r1_num_i) ? wb_data_i : regs_m[r1_num_i];
            for (int i = 0; i < 16; i++) begin
                int left;
                left = pend_m[i];
                if (wb_i && wbr_num_i == i && left > 0) left = left - 1;
                exp_rsv[i] = (left != 0);
            end
            full = (pend_m[rsv_num_i] == 3) && !(wb_i && wbr_num_i == rsv_num_i);
            check("r0_data", 32'(r0_data_o), 32'(e0));
            check("r1_data", 32'(r1_data_o), 32'(e1));
            check("reserved", 32'(reserved_o), 32'(exp_rsv));
            check("rsv_full", 32'(rsv_full_o), 32'(full));
            check("err", 32'(err_o), 32'(err_m));
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_m[i] = '0;
                pend_m[i] = 0;
            end
            err_m = 1'b0;
        end else begin
            if (wb_i) regs_m[wbr_num_i] = wb_data_i;
            for (int i = 0; i < 16; i++) begin
                bit inc, dec;
                inc = w_reserve_i && rsv_num_i == i;
                dec = wb_i && wbr_num_i == i;
                if (inc && !dec) begin
                    if (pend_m[i] < 3) pend_m[i]++;
                    else err_m = 1'b1;
                end else if (dec && !inc) begin
                    if (pend_m[i] > 0) pend_m[i]--;
                    else err_m = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] pick_reg();
        if ($urandom_range(0, 1) == 1) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;
        chk_en = 1'b0;
        err_m  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            regs_m[i] = '0;
            pend_m[i] = 0;
        end

        apply(1, 0, 0, 0, 0, 16'h0, 0, 0);
        tick();
        chk_en = 1'b1;

        // 1: plain write then read
        apply(0, 0, 0, 1, 3, 16'h1234, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 16'h0, 3, 5);
        check("t1_r0", 32'(r0_data_o), 32'h1234);
        check("t1_r1", 32'(r1_data_o), 32'h0);
        check("t1_reserved", 32'(reserved_o), 32'h0);
        tick();

        // 2: same-cycle bypass on both ports
        apply(0, 0, 0, 1, 7, 16'hBEEF, 7, 7);
        check("t2_r0_byp", 32'(r0_data_o), 32'hBEEF);
        check("t2_r1_byp", 32'(r1_data_o), 32'hBEEF);
        tick();
        apply(0, 0, 0, 0, 0, 16'h0, 7, 0);
        check("t2_r0_after", 32'(r0_data_o), 32'hBEEF);
        tick();

        // 3: reserve r2, release three cycles later
        apply(0, 1, 2, 0, 0, 16'h0, 2, 0);
        check("t3_rsv_n", 32'(reserved_o[2]), 32'h0);
        tick();
        apply(0, 0, 2, 0, 0, 16'h0, 2, 0);
        check("t3_rsv_n1", 32'(reserved_o[2]), 32'h1);
        tick();
        check("t3_rsv_n2", 32'(reserved_o[2]), 32'h1);
        tick();
        apply(0, 0, 2, 1, 2, 16'h0042, 2, 0);
        check("t3_rsv_n3", 32'(reserved_o[2]), 32'h0);
        check("t3_r0_n3", 32'(r0_data_o), 32'h0042);
        tick();
        apply(0, 0, 2, 0, 0, 16'h0, 2, 0);
        check("t3_rsv_n4", 32'(reserved_o[2]), 32'h0);
        check("t3_r0_n4", 32'(r0_data_o), 32'h0042);
        tick();

        // 4: saturate r4 then drain it
        apply(1, 0, 0, 0, 0, 16'h0, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 4, 0, 0, 16'h0, 4, 0);
            check("t4_full", 32'(rsv_full_o), (k == 3) ? 32'h1 : 32'h0);
            tick();
        end
        apply(0, 0, 4, 0, 0, 16'h0, 4, 0);
        check("t4_err", 32'(err_o), 32'h1);
        check("t4_rsv", 32'(reserved_o[4]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 4, 1, 4, 16'(16'h4400 + k), 4, 0);
            check("t4_drain", 32'(reserved_o[4]), (k == 2) ? 32'h0 : 32'h1);
            tick();
        end

        // 5: simultaneous reserve and WB on r9, then WB to unreserved r10
        apply(1, 0, 0, 0, 0, 16'h0, 0, 0);
        tick();
        apply(0, 1, 9, 0, 0, 16'h0, 9, 0);
        tick();
        apply(0, 1, 9, 1, 9, 16'h0909, 9, 0);
        tick();
        apply(0, 0, 9, 0, 0, 16'h0, 9, 0);
        check("t5_rsv9", 32'(reserved_o[9]), 32'h1);
        check("t5_r9", 32'(r0_data_o), 32'h0909);
        check("t5_err0", 32'(err_o), 32'h0);
        tick();
        apply(0, 0, 0, 1, 10, 16'hA0A0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 16'h0, 10, 0);
        check("t5_r10", 32'(r0_data_o), 32'hA0A0);
        check("t5_err1", 32'(err_o), 32'h1);
        tick();

        // 6: reset mid-operation, overriding a same-cycle WB and reserve
        for (int k = 1; k <= 3; k++) begin
            apply(0, 1, 4'(k), 0, 0, 16'h0, 0, 0);
            tick();
        end
        apply(0, 0, 0, 1, 2, 16'h2222, 0, 0);
        tick();
        apply(0, 0, 0, 1, 3, 16'h3333, 0, 0);
        tick();
        apply(1, 1, 1, 1, 1, 16'hDEAD, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 16'h0, 1, 2);
        check("t6_r1", 32'(r0_data_o), 32'h0);
        check("t6_r2", 32'(r1_data_o), 32'h0);
        check("t6_reserved", 32'(reserved_o), 32'h0);
        check("t6_err", 32'(err_o), 32'h0);
        tick();

        // randomized traffic concentrated on a few registers to hit saturation
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), pick_reg(),
                  1'($urandom_range(0, 1)), pick_reg(), 16'($urandom()),
                  pick_reg(), pick_reg());
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
